// File: rtl/mux_rr_nx1_reg_pkg.sv
// Shared constants for the N-input library muxes: arbitration modes and
// the selector-width rule reused by later N-input blocks.
package mux_rr_nx1_reg_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Selector width never collapses to zero bits, even for a single channel.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_reg_rr_grant.sv
// Combinational arbiter: picks one requester, scanning from ptr (round-robin)
// or from channel 0 (fixed priority), with explicit wrap for any channel count.
module mux_rr_nx1_reg_rr_grant
    import mux_rr_nx1_reg_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [sel_w(CHANNELS)-1:0]  ptr,
    input  logic                        rr_mode,
    output logic [CHANNELS-1:0]         gnt,
    output logic [sel_w(CHANNELS)-1:0]  gnt_idx,
    output logic                        any
);

    localparam int SEL_W = sel_w(CHANNELS);

    int start;
    int idx;

    // NOTE: every output gets a default before the scan so no path leaves a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        start   = rr_mode ? int'(ptr) : 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = start + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_nx1_reg.sv
// N-channel, WIDTH-bit arbitrated mux with valid/ready handshake on every
// channel and a single registered output stage.
module mux_rr_nx1_reg
    import mux_rr_nx1_reg_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 1,
    parameter int PwrC     = 0
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [sel_w(CHANNELS)-1:0]   out_sel
);

    localparam int   SEL_W = sel_w(CHANNELS);
    localparam logic RR_EN = (RR_MODE == MODE_RR);

    if (WIDTH < 1 || CHANNELS < 1 || PwrC < 0) begin : g_bad_params
        $error("mux_rr_nx1_reg: WIDTH and CHANNELS must be >= 1, PwrC >= 0");
    end

    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    data_q,  data_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [SEL_W-1:0]    ptr_q,   ptr_d;

    logic [CHANNELS-1:0] gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic                any;
    logic                load;
    logic [WIDTH-1:0]    gnt_data;

    mux_rr_nx1_reg_rr_grant #(
        .CHANNELS (CHANNELS)
    ) u_rr_grant (
        .req     (in_valid),
        .ptr     (ptr_q),
        .rr_mode (RR_EN),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = ~valid_q | out_ready;
    // Reset also gates the grant so no handshake can complete while held in reset.
    assign in_ready = gnt & {CHANNELS{load & reset_L}};

    // One-hot AND-OR data select keyed off the grant vector.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gnt_data = gnt_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = any;
            if (any) begin
                data_d = gnt_data;
                sel_d  = gnt_idx;
                if (RR_EN) begin
                    ptr_d = (int'(gnt_idx) == CHANNELS - 1) ? '0 : SEL_W'(int'(gnt_idx) + 1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_nx1_reg.sv
// Directed bench for three configurations (4ch RR, 4ch fixed, 3ch RR) checked
// every cycle against a queue-free behavioural model plus literal expectations.
module tb_mux_rr_nx1_reg;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] in_valid = 4'b0000;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic [3:0] ir_rr, ir_fx;
    logic [2:0] ir_c3;
    logic       ov_rr, ov_fx, ov_c3;
    logic [1:0] od_rr, od_fx, od_c3;
    logic [1:0] os_rr, os_fx, os_c3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rr_nx1_reg #(.WIDTH(2), .CHANNELS(4), .RR_MODE(1), .PwrC(0)) dut_rr (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_rr), .out_ready(out_ready), .out_valid(ov_rr),
        .out_data(od_rr), .out_sel(os_rr)
    );

    mux_rr_nx1_reg #(.WIDTH(2), .CHANNELS(4), .RR_MODE(0), .PwrC(0)) dut_fx (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_fx), .out_ready(out_ready), .out_valid(ov_fx),
        .out_data(od_fx), .out_sel(os_fx)
    );

    mux_rr_nx1_reg #(.WIDTH(2), .CHANNELS(3), .RR_MODE(1), .PwrC(0)) dut_c3 (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid[2:0]), .in_data(in_data[5:0]),
        .in_ready(ir_c3), .out_ready(out_ready), .out_valid(ov_c3),
        .out_data(od_c3), .out_sel(os_c3)
    );

    logic       ov [3];
    logic [1:0] od [3];
    logic [1:0] os [3];
    logic [3:0] ir [3];
    assign ov[0] = ov_rr;  assign ov[1] = ov_fx;  assign ov[2] = ov_c3;
    assign od[0] = od_rr;  assign od[1] = od_fx;  assign od[2] = od_c3;
    assign os[0] = os_rr;  assign os[1] = os_fx;  assign os[2] = os_c3;
    assign ir[0] = ir_rr;  assign ir[1] = ir_fx;  assign ir[2] = {1'b0, ir_c3};

    // Per-instance configuration and model state.
    int   cfg_n  [3] = '{4, 4, 3};
    bit   cfg_rr [3] = '{1'b1, 1'b0, 1'b1};
    bit   mv [3];
    int   md [3];
    int   ms [3];
    int   mp [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The channel that must win, by scanning the circular order from the start point.
    function automatic int model_grant(input int n, input bit rr, input int ptr, input logic [3:0] v);
        int start;
        start = rr ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic int chan_data(input int g);
        return int'((in_data >> (2 * g)) & 8'h03);
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int m = 0; m < 3; m++) begin
                mv[m] <= 1'b0; md[m] <= 0; ms[m] <= 0; mp[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                int g;
                g = model_grant(cfg_n[m], cfg_rr[m], mp[m], in_valid);
                if (!mv[m] || out_ready) begin
                    if (g >= 0) begin
                        mv[m] <= 1'b1;
                        md[m] <= chan_data(g);
                        ms[m] <= g;
                        mp[m] <= cfg_rr[m] ? (g + 1) % cfg_n[m] : 0;
                    end else begin
                        mv[m] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic compare_model();
        for (int m = 0; m < 3; m++) begin
            int g;
            logic [3:0] exp_ir;
            g = model_grant(cfg_n[m], cfg_rr[m], mp[m], in_valid);
            exp_ir = (reset_L && (!mv[m] || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
            check($sformatf("m%0d_out_valid", m), 32'(ov[m]), 32'(mv[m]));
            check($sformatf("m%0d_out_data", m), 32'(od[m]), 32'(md[m]));
            check($sformatf("m%0d_out_sel", m), 32'(os[m]), 32'(ms[m]));
            check($sformatf("m%0d_in_ready", m), 32'(ir[m]), 32'(exp_ir));
            check($sformatf("m%0d_onehot", m), 32'($onehot0(ir[m])), 32'd1);
        end
    endtask

    always @(negedge clk) compare_model();

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with all channels requesting.
        in_valid  = 4'b1111;
        in_data   = {2'd3, 2'd2, 2'd1, 2'd0};
        out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(ov_rr), 32'd0);
        check("rst_out_data", 32'(od_rr), 32'd0);
        check("rst_out_sel", 32'(os_rr), 32'd0);
        check("rst_in_ready", 32'(ir_rr), 32'd0);
        reset_L = 1'b1;

        // Round-robin rotation: 4ch cycles 0..3, 3ch cycles 0..2.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rot_sel_rr", 32'(os_rr), 32'(i % 4));
            check("rot_data_rr", 32'(od_rr), 32'(i % 4));
            check("rot_sel_c3", 32'(os_c3), 32'(i % 3));
            check("rot_sel_fx", 32'(os_fx), 32'd0);
        end

        // Load ch0 then ch1, then stall three cycles.
        tick(); tick();
        check("pre_stall_data", 32'(od_rr), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", 32'(od_rr), 32'd1);
            check("stall_sel", 32'(os_rr), 32'd1);
            check("stall_valid", 32'(ov_rr), 32'd1);
            #1 check("stall_in_ready", 32'(ir_rr), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("drain_refill_sel", 32'(os_rr), 32'd2);
        check("drain_refill_data", 32'(od_rr), 32'd2);

        // Sparse requests with wrap on the 3-channel instance (ptr is now 2).
        in_valid = 4'b0011;
        tick();
        check("wrap_sel_c3", 32'(os_c3), 32'd0);
        tick();
        check("next_sel_c3", 32'(os_c3), 32'd1);
        check("next_data_c3", 32'(od_c3), 32'd1);
        in_valid = 4'b0000;
        tick();
        check("idle_valid_c3", 32'(ov_c3), 32'd0);
        check("idle_hold_c3", 32'(od_c3), 32'd1);
        tick();

        // Fixed priority starves ch3 while ch1 is requesting.
        in_valid = 4'b1010;
        #1 check("fx_in_ready", 32'(ir_fx), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fx_sel", 32'(os_fx), 32'd1);
            check("fx_data", 32'(od_fx), 32'd1);
            #1 check("fx_in_ready_hold", 32'(ir_fx), 32'b0010);
        end

        // Asynchronous reset pulse in the middle of a stall.
        in_valid = 4'b1111;
        tick();
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(ov_rr), 32'd1);
        reset_L = 1'b0;
        #1;
        check("async_rst_valid", 32'(ov_rr), 32'd0);
        check("async_rst_data", 32'(od_rr), 32'd0);
        check("async_rst_sel", 32'(os_rr), 32'd0);
        check("async_rst_in_ready", 32'(ir_rr), 32'd0);
        #1 reset_L = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_sel_rr", 32'(os_rr), 32'd0);
        check("post_rst_sel_c3", 32'(os_c3), 32'd0);
        check("post_rst_valid", 32'(ov_rr), 32'd1);
        tick();
        check("post_rst_next_rr", 32'(os_rr), 32'd1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_nx1_reg.md
Name: mux_rr_nx1_reg

Overview:
Parametrised N-channel, W-bit multiplexer; successor to the 2x1 1-bit and 2-bit library muxes.
- Selection is made internally by a fixed-priority or round-robin arbiter, not by an external selector.
- Per-channel valid/ready handshake; one registered output stage.
- Sits between multiple producer FIFOs/registers and a single consumer in the synthesised datapath.

Parameters:
- WIDTH, 2, data bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=1, need not be a power of 2).
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- PwrC, 0, power-count weight for the power tooling; no functional effect.

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous active-low reset.
- in_valid  in  CHANNELS  per-channel request; bit i belongs to channel i.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  one-hot grant/accept; at most one bit high.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data/out_sel hold a word.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  SEL_W  index of the channel that supplied out_data; SEL_W = max(1, clog2(CHANNELS)).

Behaviour:
- Clock and reset: one clock domain, clk. reset_L is asynchronous and active-low.
- While reset_L=0:
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready=0 regardless of other inputs.
- Load condition: load = ~out_valid | out_ready.
- Grant (combinational):
  - RR_MODE=1: g = first i with in_valid[i]=1, scanning ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1.
  - RR_MODE=0: g = lowest i with in_valid[i]=1.
  - in_ready[g] = load. All other in_ready bits = 0. If no in_valid bit is set, in_ready = 0.
- Rising edge with load=1 and any in_valid:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g == CHANNELS-1) ? 0 : g+1. Wrap is explicit, so it is correct for non-power-of-2 CHANNELS.
- Rising edge with load=1 and no in_valid:
  - out_valid <= 0.
  - out_data, out_sel and ptr hold.
- Rising edge with load=0 (stall):
  - All registers hold; out_data/out_sel must not change while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Input accepted at edge k is visible on out_data after edge k, i.e. 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Simultaneous drain and refill: out_valid=1, out_ready=1 and a request pending. The old word is consumed and the new word loads on the same edge; no bubble.
- Fairness: with all channels continuously valid and out_ready=1 in RR_MODE=1, grants are 0,1,...,CHANNELS-1,0,... Each channel waits at most CHANNELS-1 grants.
- ptr changes only on a successful load.
- RR_MODE=0 keeps ptr at 0 and does not use it.
- CHANNELS=1: g=0 always, out_sel=0, ptr stays 0.
- Reset asserted mid-stall: the held word is dropped and no handshake completes. After release, the first grant starts from channel 0.
- Register timing: register updates carry the library flip-flop clock-to-Q of 3.1 ns. Combinational grant/ready paths are built from and_lib/or_lib/not_lib-compatible logic so Yosys maps them to library cells.
- Out-of-range: there is no combination of in_valid that can raise more than one in_ready bit; the bench checks this as an assertion.

Decomposition:
- Shared include file `mux_defs.vh`:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - SEL_W computation macro, reused by later N-input library blocks.
- Natural sub-module `rr_grant`: purely combinational.
  - Inputs: req[CHANNELS], ptr[SEL_W], rr_mode.
  - Outputs: gnt[CHANNELS] one-hot, gnt_idx[SEL_W], any.
- Top level holds the output register, ptr register and load logic.

Test Plan:
- Reset: hold reset_L=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Release -> first accepted word comes from ch0.
- RR rotation: WIDTH=2, CHANNELS=4, RR_MODE=1, in_valid=4'b1111, in_data={2'd3,2'd2,2'd1,2'd0}, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data equal to out_sel each cycle.
- Stall: after ch1 loads (out_data=1), drive out_ready=0 for 3 cycles -> out_data=1, out_sel=1, out_valid=1 held and in_ready=0. On out_ready=1 -> ch2 loads on the same edge.
- Sparse/wrap: CHANNELS=3, ptr=2, in_valid=3'b011 -> ch0 granted, then ptr=1, so ch1 is next. in_valid=0 -> out_valid drops after one edge, out_data holds its last value.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held -> ch1 granted every cycle and ch3 starved; in_ready=4'b0010.
- Reset mid-operation: out_valid=1, out_ready=0, then pulse reset_L low for 2 ns between edges -> outputs clear immediately (asynchronous). The next grant after release comes from ch0.
